// File: rtl/vga_sync_decoder.sv
// VGA receive monitor: recovers pixel position, data-enable and frame timing from hs/vs/RGB sampled at pix_ce.
// Outputs register one clock after each pix_ce sample and hold between samples; no backpressure, pulses last one clock.
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACT       = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACT       = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       CLK100MHz,
    input  logic       RST,
    input  logic       pix_ce,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic [2:0] vga_r,
    input  logic [2:0] vga_g,
    input  logic [2:0] vga_b,
    output logic [9:0] rx_x,
    output logic [9:0] rx_y,
    output logic       rx_de,
    output logic [2:0] rx_r,
    output logic [2:0] rx_g,
    output logic [2:0] rx_b,
    output logic       locked,
    output logic       end_of_frame,
    output logic       err_h,
    output logic       err_v
);
    localparam int              GW      = $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0]      H_LO    = 10'(H_SYNC + H_BP);
    localparam logic [9:0]      H_HI    = 10'(H_SYNC + H_BP + H_ACT - 1);
    localparam logic [9:0]      V_LO    = 10'(V_SYNC + V_BP);
    localparam logic [9:0]      V_HI    = 10'(V_SYNC + V_BP + V_ACT - 1);
    localparam logic [10:0]     H_TOT   = 11'(H_TOTAL);
    localparam logic [10:0]     V_TOT   = 11'(V_TOTAL);
    localparam logic [GW-1:0]   LOCK_N  = GW'(LOCK_FRAMES);
    localparam logic [9:0]      CNT_MAX = 10'd1023;

    typedef enum logic [1:0] {UNLOCKED, MEASURE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic            hs_prev_q, hs_prev_d;
    logic            vs_prev_q, vs_prev_d;
    logic [9:0]      h_cnt_q, h_cnt_d;
    logic [9:0]      v_cnt_q, v_cnt_d;
    logic [GW-1:0]   good_q, good_d;
    logic            bad_q, bad_d;
    logic [9:0]      rx_x_q, rx_x_d;
    logic [9:0]      rx_y_q, rx_y_d;
    logic            rx_de_q, rx_de_d;
    logic [2:0]      rx_r_q, rx_r_d;
    logic [2:0]      rx_g_q, rx_g_d;
    logic [2:0]      rx_b_q, rx_b_d;
    logic            eof_q, eof_d;
    logic            err_h_q, err_h_d;
    logic            err_v_q, err_v_d;

    logic hs_fall, vs_fall, line_bad, frame_bad, act;

    assign hs_fall   = hs_prev_q & ~vga_hs;
    assign vs_fall   = vs_prev_q & ~vga_vs;
    // A line that ends on the vsync edge still belongs to the frame being closed.
    assign line_bad  = hs_fall && (({1'b0, h_cnt_q} + 11'd1) != H_TOT);
    assign frame_bad = vs_fall && (({1'b0, v_cnt_q} + {10'd0, hs_fall}) != V_TOT);
    assign act       = (state_q == LOCKED) &&
                       (h_cnt_q >= H_LO) && (h_cnt_q <= H_HI) &&
                       (v_cnt_q >= V_LO) && (v_cnt_q <= V_HI);

    always_comb begin
        state_d   = state_q;
        hs_prev_d = hs_prev_q;
        vs_prev_d = vs_prev_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        good_d    = good_q;
        bad_d     = bad_q;
        rx_x_d    = rx_x_q;
        rx_y_d    = rx_y_q;
        rx_de_d   = rx_de_q;
        rx_r_d    = rx_r_q;
        rx_g_d    = rx_g_q;
        rx_b_d    = rx_b_q;
        eof_d     = 1'b0;
        err_h_d   = 1'b0;
        err_v_d   = 1'b0;

        if (pix_ce) begin
            hs_prev_d = vga_hs;
            vs_prev_d = vga_vs;

            if (hs_fall)                h_cnt_d = 10'd0;
            else if (h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + 10'd1;

            if (vs_fall)                           v_cnt_d = 10'd0;
            else if (hs_fall && v_cnt_q != CNT_MAX) v_cnt_d = v_cnt_q + 10'd1;

            case (state_q)
                UNLOCKED: begin
                    if (vs_fall) begin
                        state_d = MEASURE;
                        good_d  = '0;
                        bad_d   = 1'b0;
                    end
                end
                MEASURE: begin
                    if (line_bad) bad_d = 1'b1;
                    if (vs_fall) begin
                        if (!frame_bad && !bad_q && !line_bad) good_d = good_q + GW'(1);
                        else                                   good_d = '0;
                        bad_d = 1'b0;
                        if (good_d == LOCK_N) state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    err_h_d = line_bad;
                    err_v_d = frame_bad;
                    if (line_bad || frame_bad) state_d = UNLOCKED;
                end
                default: state_d = UNLOCKED;
            endcase

            eof_d   = vs_fall && (state_d == LOCKED);
            rx_de_d = act;
            if (act) begin
                rx_x_d = h_cnt_q - H_LO;
                rx_y_d = v_cnt_q - V_LO;
            end
            rx_r_d = act ? vga_r : 3'd0;
            rx_g_d = act ? vga_g : 3'd0;
            rx_b_d = act ? vga_b : 3'd0;
        end
    end

    always_ff @(posedge CLK100MHz or posedge RST) begin
        if (RST) begin
            state_q   <= UNLOCKED;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            good_q    <= '0;
            bad_q     <= 1'b0;
            rx_x_q    <= 10'd0;
            rx_y_q    <= 10'd0;
            rx_de_q   <= 1'b0;
            rx_r_q    <= 3'd0;
            rx_g_q    <= 3'd0;
            rx_b_q    <= 3'd0;
            eof_q     <= 1'b0;
            err_h_q   <= 1'b0;
            err_v_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            rx_x_q    <= rx_x_d;
            rx_y_q    <= rx_y_d;
            rx_de_q   <= rx_de_d;
            rx_r_q    <= rx_r_d;
            rx_g_q    <= rx_g_d;
            rx_b_q    <= rx_b_d;
            eof_q     <= eof_d;
            err_h_q   <= err_h_d;
            err_v_q   <= err_v_d;
        end
    end

    assign rx_x         = rx_x_q;
    assign rx_y         = rx_y_q;
    assign rx_de        = rx_de_q;
    assign rx_r         = rx_r_q;
    assign rx_g         = rx_g_q;
    assign rx_b         = rx_b_q;
    assign locked       = (state_q == LOCKED);
    assign end_of_frame = eof_q;
    assign err_h        = err_h_q;
    assign err_v        = err_v_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder with shrunken video timing; generator frames feed a reference model whose
// per-sample expectations are queued and compared against the DUT outputs every clock.
module tb_vga_sync_decoder;
    localparam int HS = 4, HB = 3, HA = 10, HT = 20;
    localparam int VS = 2, VB = 2, VA = 5,  VT = 12;
    localparam int LOCK = 2;
    localparam int HL = HS + HB + 1;   // first generator pixel whose sample lands in the window
    localparam int VL = VS + VB;

    typedef struct packed {
        logic [31:0] tag;
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  r;
        logic [2:0]  g;
        logic [2:0]  b;
        logic        lk;
        logic        eof;
        logic        eh;
        logic        ev;
    } exp_t;

    logic       CLK100MHz = 1'b0;
    logic       RST = 1'b1;
    logic       pix_ce = 1'b0;
    logic       vga_hs = 1'b1;
    logic       vga_vs = 1'b1;
    logic [2:0] vga_r = 3'd0, vga_g = 3'd0, vga_b = 3'd0;
    logic [9:0] rx_x, rx_y;
    logic       rx_de;
    logic [2:0] rx_r, rx_g, rx_b;
    logic       locked, end_of_frame, err_h, err_v;

    int   errors = 0;
    int   checks = 0;
    logic [31:0] cyc = 0;
    exp_t sb[$];
    exp_t cur = '0;

    // reference model state
    bit       m_lk = 0, m_meas = 0, m_runbad = 0;
    int       m_run = 0;
    int       last_len = 0, last_nl = 0;
    logic [9:0] last_x = 0, last_y = 0;

    vga_sync_decoder #(
        .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_TOTAL(VT),
        .LOCK_FRAMES(LOCK)
    ) dut (
        .CLK100MHz(CLK100MHz), .RST(RST), .pix_ce(pix_ce),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .rx_x(rx_x), .rx_y(rx_y), .rx_de(rx_de),
        .rx_r(rx_r), .rx_g(rx_g), .rx_b(rx_b),
        .locked(locked), .end_of_frame(end_of_frame),
        .err_h(err_h), .err_v(err_v)
    );

    always #5 CLK100MHz = ~CLK100MHz;
    always @(posedge CLK100MHz) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: adopt the expectation of a sample on the clock its result appears, then hold it.
    always @(negedge CLK100MHz) begin
        if (RST) cur = '0;
        else if (sb.size() > 0 && sb[0].tag == cyc) cur = sb.pop_front();
        else begin
            cur.eof = 1'b0;
            cur.eh  = 1'b0;
            cur.ev  = 1'b0;
        end
        chk("locked",       locked,       cur.lk);
        chk("rx_de",        rx_de,        cur.de);
        chk("rx_x",         rx_x,         cur.x);
        chk("rx_y",         rx_y,         cur.y);
        chk("rx_r",         rx_r,         cur.r);
        chk("rx_g",         rx_g,         cur.g);
        chk("rx_b",         rx_b,         cur.b);
        chk("end_of_frame", end_of_frame, cur.eof);
        chk("err_h",        err_h,        cur.eh);
        chk("err_v",        err_v,        cur.ev);
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK100MHz);
            #1;
        end
    endtask

    task automatic do_reset();
        idle(1);
        RST = 1'b1;
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_rx_de",  rx_de, 0);
        chk("rst_rx_x",   rx_x, 0);
        chk("rst_rx_y",   rx_y, 0);
        chk("rst_rgb",    {rx_r, rx_g, rx_b}, 0);
        chk("rst_pulses", {end_of_frame, err_h, err_v}, 0);
        @(posedge CLK100MHz);
        #1;
        RST = 1'b0;
        m_lk = 0; m_meas = 0; m_runbad = 0; m_run = 0;
        last_x = 0; last_y = 0;
    endtask

    // One pixel sample: reference model decides the outcome, then the sample is driven.
    task automatic pixel(input int hp, input int vl);
        exp_t e;
        logic [2:0] r, g, b;
        bit lbad, vsf, fbad;
        r = 3'($urandom_range(0, 7));
        g = 3'($urandom_range(0, 7));
        b = 3'($urandom_range(0, 7));
        if (hp == HL && vl == VL)               begin r = 3'd7; g = 3'd0; b = 3'd0; end
        if (hp == HL + HA - 1 && vl == VL + VA - 1) begin r = 3'd0; g = 3'd0; b = 3'd7; end

        e = '0;
        e.de = m_lk && hp >= HL && hp <= HL + HA - 1 && vl >= VL && vl <= VL + VA - 1;
        if (e.de) begin
            last_x = 10'(hp - HL);
            last_y = 10'(vl - VL);
            e.r = r; e.g = g; e.b = b;
        end
        e.x = last_x;
        e.y = last_y;

        if (hp == 0) begin
            lbad = (last_len != HT);
            vsf  = (vl == 0);
            fbad = vsf && (last_nl != VT);
            if (m_lk) begin
                e.eh = lbad;
                e.ev = fbad;
                if (lbad || fbad) m_lk = 0;
                else if (vsf)     e.eof = 1'b1;
            end else if (m_meas) begin
                m_runbad = m_runbad | lbad;
                if (vsf) begin
                    m_run = (!fbad && !m_runbad) ? m_run + 1 : 0;
                    m_runbad = 0;
                    if (m_run == LOCK) begin
                        m_lk = 1; m_meas = 0; e.eof = 1'b1;
                    end
                end
            end else if (vsf) begin
                m_meas = 1; m_run = 0; m_runbad = 0;
            end
        end
        e.lk = m_lk;

        vga_hs = (hp < HS) ? 1'b0 : 1'b1;
        vga_vs = (vl < VS) ? 1'b0 : 1'b1;
        vga_r = r; vga_g = g; vga_b = b;
        pix_ce = 1'b1;
        @(posedge CLK100MHz);
        #1;
        pix_ce = 1'b0;
        e.tag = cyc;
        sb.push_back(e);
        idle($urandom_range(0, 3));
    endtask

    task automatic frame(input int nl, input int short_vl, input int rst_vl, input int pause_vl);
        for (int vl = 0; vl < nl; vl++) begin
            int len;
            len = (vl == short_vl) ? HT - 1 : HT;
            for (int hp = 0; hp < len; hp++) begin
                if (vl == rst_vl && hp == 10) do_reset();
                if (vl == pause_vl && hp == HL + 3) idle(100);
                pixel(hp, vl);
            end
            last_len = len;
        end
        last_nl = nl;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        idle(3);
        chk("reset_locked", locked, 0);
        chk("reset_rx_de",  rx_de, 0);
        chk("reset_pulses", {end_of_frame, err_h, err_v}, 0);
        RST = 1'b0;
        idle(2);

        repeat (4) frame(VT, -1, -1, -1);     // lock at 3rd vsync, then a locked frame
        frame(VT, VL + 1, -1, -1);            // one short line while locked
        repeat (3) frame(VT, -1, -1, -1);     // re-lock
        frame(VT - 1, -1, -1, -1);            // short frame while locked
        repeat (3) frame(VT, -1, -1, -1);
        frame(VT, -1, 3, -1);                 // reset mid-line in a locked frame
        repeat (2) frame(VT, -1, -1, -1);
        frame(VT, -1, -1, VL + 2);            // pix_ce stall inside active video
        frame(VT, -1, -1, -1);

        idle(5);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the pong VGA generator. Samples the 640x480@60 VGA bus (vga_hs, vga_vs, 3-bit RGB) on the 100 MHz system clock at the pixel-rate enable.
- Recovers pixel coordinates, data-enable and frame boundaries, and checks sync timing against the configured totals.
- Used as an in-fabric monitor for OSD/overlay logic and as a self-checking sink in the pong_game benches.

Parameters:
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch in pixels
- H_ACT, 640, active pixels per line
- H_TOTAL, 800, pixels per line
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch in lines
- V_ACT, 480, active lines per frame
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to assert locked

Ports:
- CLK100MHz  in  1  system clock
- RST  in  1  asynchronous active-high reset
- pix_ce  in  1  pixel-rate enable (1 of every 4 clocks for 25 MHz); all sampling is qualified by it
- vga_hs  in  1  horizontal sync, active low
- vga_vs  in  1  vertical sync, active low
- vga_r, vga_g, vga_b  in  3 each  pixel colour
- rx_x  out  10  active pixel column, 0..H_ACT-1
- rx_y  out  10  active line, 0..V_ACT-1
- rx_de  out  1  active-video strobe
- rx_r, rx_g, rx_b  out  3 each  registered colour
- locked  out  1  timing locked
- end_of_frame  out  1  single-clock pulse at each vsync falling edge while locked
- err_h  out  1  single-clock pulse on bad line length
- err_v  out  1  single-clock pulse on bad frame length

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All outputs 0; FSM goes to UNLOCKED.
  - hs_d and vs_d preset to 1; h_cnt and v_cnt cleared; good-frame count cleared.
  - Reset mid-frame discards all progress. Re-lock needs LOCK_FRAMES full frames measured after the first vsync fall following reset release.
- Sampling: all state updates occur only on clocks with pix_ce=1. With pix_ce=0 every register holds, and pulse outputs deassert on the next clock.
- hs_fall = hs_d & ~vga_hs; vs_fall = vs_d & ~vga_vs. hs_d and vs_d update on every pix_ce.
- h_cnt (10 bit):
  - hs_fall: h_cnt <= 0; line_len = h_cnt+1 is compared to H_TOTAL.
  - Otherwise h_cnt increments, saturating at 1023.
- v_cnt (10 bit):
  - hs_fall: v_cnt increments, saturating at 1023.
  - vs_fall: v_cnt <= 0; frame_len = v_cnt + hs_fall is compared to V_TOTAL.
  - When vs_fall and hs_fall occur on the same sample, vs_fall wins the v_cnt update and that line counts toward frame_len.
- FSM states:
  - UNLOCKED: on vs_fall, go to MEASURE with good count 0. No error pulses.
  - MEASURE:
    - Any line_len != H_TOTAL sets a frame-bad flag.
    - On vs_fall, if frame_len == V_TOTAL and the flag is clear, increment good count; otherwise set good count 0. Clear the flag.
    - When good count reaches LOCK_FRAMES, go to LOCKED and set locked=1 on that same vs_fall.
  - LOCKED:
    - line_len != H_TOTAL: err_h pulses; go to UNLOCKED.
    - frame_len != V_TOTAL: err_v pulses; go to UNLOCKED.
    - Both on the same sample: both pulses fire.
    - locked drops on the same clock as the error pulse.
- Active window:
  - h_act = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1], i.e. 144..783.
  - v_act = v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACT-1], i.e. 35..514.
- Outputs:
  - Latency is one clock after the pix_ce sample (registered).
  - rx_de = locked & h_act & v_act, evaluated with the pre-update counter values of that sample.
  - rx_x = h_cnt-144 and rx_y = v_cnt-35 when rx_de, else hold the last value.
  - rx_r, rx_g and rx_b are captured on every pix_ce; they are forced to 0 when not rx_de.
- end_of_frame: one clock on vs_fall when locked is already 1 or becomes 1 on that sample.
- Counter saturation (sync lost) shows up as a length error at the next edge; with no edges the block stays in its current state, and rx_de stays active only while the counters remain inside the window.

Test Plan:
- Reset, then 3 nominal 800x525 frames (pix_ce every 4th clock) -> locked=1 at the 3rd vs_fall (2 full frames measured); end_of_frame pulses from that edge onward; err_h and err_v stay 0.
- Locked; drive pixel (x=0, y=0) as RGB 7/0/0 and (639, 479) as 0/0/7 -> rx_de is 1 at exactly 640x480 samples per frame; rx_x/rx_y/rx_r/rx_b match at 1-clock latency.
- Locked; shorten one line to 799 pixels -> err_h single pulse, locked=0 on the same clock, rx_de=0; re-lock after 2 further good frames.
- Locked; frame of 524 lines -> err_v pulse at that vs_fall; FSM in UNLOCKED; no end_of_frame on that edge.
- RST asserted mid-line at h_cnt=400 for 1 clock -> all outputs 0 immediately; no err pulses; locked returns 2 frames after the next vs_fall.
- Hold pix_ce=0 for 100 clocks mid-active -> rx_x/rx_y frozen; counters resume with no error once pix_ce restarts.
